// File: rtl/instr_compressor.sv
// Instruction compressor: splits an RV32 word into three fields, searches the
// loadable field dictionaries one index per cycle and emits a key word on a full hit.
module instr_compressor #(
  parameter int unsigned FIELD1_VAL_WIDTH = 7,
  parameter int unsigned FIELD2_VAL_WIDTH = 10,
  parameter int unsigned FIELD3_VAL_WIDTH = 15,
  parameter int unsigned FIELD1_KEY_WIDTH = 3,
  parameter int unsigned FIELD2_KEY_WIDTH = 5,
  parameter int unsigned FIELD3_KEY_WIDTH = 8
) (
  input  logic                                                        clk,
  input  logic                                                        reset,
  input  logic                                                        dict_clear,
  input  logic                                                        dict1_write_enable,
  input  logic [FIELD1_VAL_WIDTH-1:0]                                 dict1_write_val,
  input  logic                                                        dict2_write_enable,
  input  logic [FIELD2_VAL_WIDTH-1:0]                                 dict2_write_val,
  input  logic                                                        dict3_write_enable,
  input  logic [FIELD3_VAL_WIDTH-1:0]                                 dict3_write_val,
  input  logic                                                        in_valid,
  output logic                                                        in_ready,
  input  logic [31:0]                                                 in_instr,
  output logic                                                        out_valid,
  input  logic                                                        out_ready,
  output logic                                                        out_compressed,
  output logic [FIELD1_KEY_WIDTH+FIELD2_KEY_WIDTH+FIELD3_KEY_WIDTH-1:0] out_key,
  output logic [31:0]                                                 out_instr,
  output logic [31:0]                                                 stat_total,
  output logic [31:0]                                                 stat_compressed
);

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned STAT_W  = 32;
  localparam int unsigned K1      = FIELD1_KEY_WIDTH;
  localparam int unsigned K2      = FIELD2_KEY_WIDTH;
  localparam int unsigned K3      = FIELD3_KEY_WIDTH;
  localparam int unsigned KEY_W   = K1 + K2 + K3;
  localparam int unsigned DEPTH1  = 1 << K1;
  localparam int unsigned DEPTH2  = 1 << K2;
  localparam int unsigned DEPTH3  = 1 << K3;
  localparam int unsigned CNT1_W  = K1 + 1;
  localparam int unsigned CNT2_W  = K2 + 1;
  localparam int unsigned CNT3_W  = K3 + 1;
  localparam int unsigned KMAX    = (K1 > K2) ? ((K1 > K3) ? K1 : K3) : ((K2 > K3) ? K2 : K3);
  localparam int unsigned IDX_W   = KMAX + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_SEARCH, ST_DONE} state_e;

  logic [FIELD1_VAL_WIDTH-1:0] dict1_q [DEPTH1];
  logic [FIELD2_VAL_WIDTH-1:0] dict2_q [DEPTH2];
  logic [FIELD3_VAL_WIDTH-1:0] dict3_q [DEPTH3];
  logic [CNT1_W-1:0]           cnt1_q;
  logic [CNT2_W-1:0]           cnt2_q;
  logic [CNT3_W-1:0]           cnt3_q;

  state_e               state_q, state_d;
  logic [INSTR_W-1:0]   instr_q, instr_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [2:0]           found_q, found_d;
  logic [2:0]           res_q, res_d;
  logic [K1-1:0]        key1_q, key1_d;
  logic [K2-1:0]        key2_q, key2_d;
  logic [K3-1:0]        key3_q, key3_d;
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;
  logic                 out_comp_q, out_comp_d;
  logic [KEY_W-1:0]     out_key_q, out_key_d;
  logic [INSTR_W-1:0]   out_instr_q, out_instr_d;
  logic [STAT_W-1:0]    stat_total_q, stat_total_d;
  logic [STAT_W-1:0]    stat_comp_q, stat_comp_d;

  logic                        wr_ok;
  logic [FIELD1_VAL_WIDTH-1:0] fld1;
  logic [FIELD2_VAL_WIDTH-1:0] fld2;
  logic [FIELD3_VAL_WIDTH-1:0] fld3;

  assign wr_ok = (state_q == ST_IDLE);
  assign fld1  = instr_q[INSTR_W-1 -: FIELD1_VAL_WIDTH];
  assign fld2  = instr_q[FIELD3_VAL_WIDTH +: FIELD2_VAL_WIDTH];
  assign fld3  = instr_q[FIELD3_VAL_WIDTH-1:0];

  // Dictionary storage: append-only, saturating, untouched by reset
  always_ff @(posedge clk) begin
    if (dict_clear) begin
      cnt1_q <= '0;
      cnt2_q <= '0;
      cnt3_q <= '0;
    end else if (wr_ok) begin
      if (dict1_write_enable && (cnt1_q < CNT1_W'(DEPTH1))) begin
        dict1_q[cnt1_q[K1-1:0]] <= dict1_write_val;
        cnt1_q                  <= cnt1_q + CNT1_W'(1);
      end
      if (dict2_write_enable && (cnt2_q < CNT2_W'(DEPTH2))) begin
        dict2_q[cnt2_q[K2-1:0]] <= dict2_write_val;
        cnt2_q                  <= cnt2_q + CNT2_W'(1);
      end
      if (dict3_write_enable && (cnt3_q < CNT3_W'(DEPTH3))) begin
        dict3_q[cnt3_q[K3-1:0]] <= dict3_write_val;
        cnt3_q                  <= cnt3_q + CNT3_W'(1);
      end
    end
  end

  // Control and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      instr_q      <= '0;
      idx_q        <= '0;
      found_q      <= '0;
      res_q        <= '0;
      key1_q       <= '0;
      key2_q       <= '0;
      key3_q       <= '0;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      out_comp_q   <= 1'b0;
      out_key_q    <= '0;
      out_instr_q  <= '0;
      stat_total_q <= '0;
      stat_comp_q  <= '0;
    end else begin
      state_q      <= state_d;
      instr_q      <= instr_d;
      idx_q        <= idx_d;
      found_q      <= found_d;
      res_q        <= res_d;
      key1_q       <= key1_d;
      key2_q       <= key2_d;
      key3_q       <= key3_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      out_comp_q   <= out_comp_d;
      out_key_q    <= out_key_d;
      out_instr_q  <= out_instr_d;
      stat_total_q <= stat_total_d;
      stat_comp_q  <= stat_comp_d;
    end
  end

  // Next-state: one dictionary index compared per SEARCH cycle
  always_comb begin
    state_d      = state_q;
    instr_d      = instr_q;
    idx_d        = idx_q;
    found_d      = found_q;
    res_d        = res_q;
    key1_d       = key1_q;
    key2_d       = key2_q;
    key3_d       = key3_q;
    out_valid_d  = out_valid_q;
    out_comp_d   = out_comp_q;
    out_key_d    = out_key_q;
    out_instr_d  = out_instr_q;
    stat_total_d = stat_total_q;
    stat_comp_d  = stat_comp_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready_q) begin
          state_d = ST_SEARCH;
          instr_d = in_instr;
          idx_d   = '0;
          found_d = '0;
          res_d   = '0;
        end
      end
      ST_SEARCH: begin
        if (!res_q[0]) begin
          if (cnt1_q == '0 || idx_q >= IDX_W'(cnt1_q)) begin
            res_d[0] = 1'b1;
          end else if (dict1_q[idx_q[K1-1:0]] == fld1) begin
            found_d[0] = 1'b1;
            res_d[0]   = 1'b1;
            key1_d     = idx_q[K1-1:0];
          end else if ((idx_q + IDX_W'(1)) == IDX_W'(cnt1_q)) begin
            res_d[0] = 1'b1;
          end
        end
        if (!res_q[1]) begin
          if (cnt2_q == '0 || idx_q >= IDX_W'(cnt2_q)) begin
            res_d[1] = 1'b1;
          end else if (dict2_q[idx_q[K2-1:0]] == fld2) begin
            found_d[1] = 1'b1;
            res_d[1]   = 1'b1;
            key2_d     = idx_q[K2-1:0];
          end else if ((idx_q + IDX_W'(1)) == IDX_W'(cnt2_q)) begin
            res_d[1] = 1'b1;
          end
        end
        if (!res_q[2]) begin
          if (cnt3_q == '0 || idx_q >= IDX_W'(cnt3_q)) begin
            res_d[2] = 1'b1;
          end else if (dict3_q[idx_q[K3-1:0]] == fld3) begin
            found_d[2] = 1'b1;
            res_d[2]   = 1'b1;
            key3_d     = idx_q[K3-1:0];
          end else if ((idx_q + IDX_W'(1)) == IDX_W'(cnt3_q)) begin
            res_d[2] = 1'b1;
          end
        end
        if (&res_d) begin
          state_d     = ST_DONE;
          out_valid_d = 1'b1;
          out_comp_d  = &found_d;
          out_key_d   = (&found_d) ? {key1_d, key2_d, key3_d} : '0;
          out_instr_d = instr_q;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d      = ST_IDLE;
          out_valid_d  = 1'b0;
          stat_total_d = stat_total_q + STAT_W'(1);
          stat_comp_d  = stat_comp_q + STAT_W'(out_comp_q);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    in_ready_d = (state_d == ST_IDLE);
  end

  assign in_ready        = in_ready_q;
  assign out_valid       = out_valid_q;
  assign out_compressed  = out_comp_q;
  assign out_key         = out_key_q;
  assign out_instr       = out_instr_q;
  assign stat_total      = stat_total_q;
  assign stat_compressed = stat_comp_q;

endmodule

// File: tb/tb_instr_compressor.sv
// Scoreboard bench for instr_compressor: directed dictionary loads and queries,
// expected results queued at issue and compared by an independent output monitor.
module tb_instr_compressor;

  typedef struct {
    logic [31:0] instr;
    logic        comp;
    logic [15:0] key;
    int          lat;
    int          t;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        dict_clear;
  logic        dict1_write_enable;
  logic [6:0]  dict1_write_val;
  logic        dict2_write_enable;
  logic [9:0]  dict2_write_val;
  logic        dict3_write_enable;
  logic [14:0] dict3_write_val;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic        out_compressed;
  logic [15:0] out_key;
  logic [31:0] out_instr;
  logic [31:0] stat_total;
  logic [31:0] stat_compressed;

  exp_t sb_q[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   cyc = 0;
  int   exp_total = 0;
  int   exp_comp = 0;

  instr_compressor dut (
    .clk                (clk),
    .reset              (reset),
    .dict_clear         (dict_clear),
    .dict1_write_enable (dict1_write_enable),
    .dict1_write_val    (dict1_write_val),
    .dict2_write_enable (dict2_write_enable),
    .dict2_write_val    (dict2_write_val),
    .dict3_write_enable (dict3_write_enable),
    .dict3_write_val    (dict3_write_val),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .in_instr           (in_instr),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .out_compressed     (out_compressed),
    .out_key            (out_key),
    .out_instr          (out_instr),
    .stat_total         (stat_total),
    .stat_compressed    (stat_compressed)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endtask

  task automatic wr1(input logic [6:0] v);
    dict1_write_enable = 1'b1; dict1_write_val = v;
    @(negedge clk);
    dict1_write_enable = 1'b0;
  endtask

  task automatic wr2(input logic [9:0] v);
    dict2_write_enable = 1'b1; dict2_write_val = v;
    @(negedge clk);
    dict2_write_enable = 1'b0;
  endtask

  task automatic wr3(input logic [14:0] v);
    dict3_write_enable = 1'b1; dict3_write_val = v;
    @(negedge clk);
    dict3_write_enable = 1'b0;
  endtask

  task automatic clear_dicts();
    dict_clear = 1'b1;
    @(negedge clk);
    dict_clear = 1'b0;
  endtask

  // Offer one instruction; when expect_out is set the expected result is queued
  task automatic send(input logic [31:0] instr, input logic comp, input logic [15:0] key,
                      input int lat, input bit expect_out);
    int guard = 0;
    while (!in_ready && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      n_total++;
      $display("FAIL send_timeout: in_ready=%b, required 1", in_ready);
    end
    in_valid = 1'b1;
    in_instr = instr;
    if (expect_out) begin
      sb_q.push_back('{instr, comp, key, lat, cyc});
      exp_total++;
      if (comp) exp_comp++;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int guard = 0;
    while (!(in_ready && sb_q.size() == 0) && guard < 600) begin
      @(negedge clk);
      guard++;
    end
    if (!(in_ready && sb_q.size() == 0)) begin
      n_total++;
      $display("FAIL %s_timeout: in_ready=%b pending=%0d, required idle with 0 pending",
               tag, in_ready, sb_q.size());
    end
  endtask

  // Output monitor: compares each new result against the oldest queued expectation
  initial begin : monitor
    logic prev_valid;
    exp_t e;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (out_valid && !prev_valid) begin
        if (sb_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_output: out_valid=1 out_instr=%h, required no output", out_instr);
        end else begin
          e = sb_q.pop_front();
          check("out_compressed", 32'(out_compressed), 32'(e.comp));
          check("out_key", 32'(out_key), 32'(e.key));
          check("out_instr", out_instr, e.instr);
          check("latency", 32'(cyc - e.t), 32'(e.lat));
        end
      end
      prev_valid = out_valid;
    end
  end

  initial begin : driver
    int g;
    int seen;
    reset = 1'b1; dict_clear = 1'b0;
    dict1_write_enable = 1'b0; dict1_write_val = '0;
    dict2_write_enable = 1'b0; dict2_write_val = '0;
    dict3_write_enable = 1'b0; dict3_write_val = '0;
    in_valid = 1'b0; in_instr = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_compressed", 32'(out_compressed), 32'd0);
    check("rst_out_key", 32'(out_key), 32'd0);
    check("rst_out_instr", out_instr, 32'd0);
    check("rst_stat_total", stat_total, 32'd0);
    check("rst_stat_compressed", stat_compressed, 32'd0);

    // Empty dictionaries: minimum latency, pass-through
    clear_dicts();
    send(32'h0000_0013, 1'b0, 16'h0000, 2, 1'b1);
    wait_idle("empty");

    // Basic hit in all three dictionaries
    clear_dicts();
    for (int i = 0; i < 8; i++) wr1(7'(i));
    for (int i = 0; i < 8; i++) wr2((i == 3) ? 10'h0A5 : 10'h100 + 10'(i));
    for (int i = 0; i < 20; i++) wr3((i == 17) ? 15'h0213 : 15'h4000 + 15'(i));
    send({7'h00, 10'h0A5, 15'h0213}, 1'b1, {3'd0, 5'd3, 8'd17}, 19, 1'b1);
    wait_idle("basic");

    // Duplicate dict2 value: lowest index wins
    clear_dicts();
    for (int i = 0; i < 8; i++) wr1(7'(i));
    for (int i = 0; i < 16; i++) wr2((i == 4 || i == 9) ? 10'h2AA : 10'h100 + 10'(i));
    for (int i = 0; i < 4; i++) wr3(15'h4000 + 15'(i));
    send({7'd5, 10'h2AA, 15'h4002}, 1'b1, {3'd5, 5'd4, 8'd2}, 7, 1'b1);
    wait_idle("dup");

    // Full dict3 with a dropped 257th write; field3 absent
    clear_dicts();
    wr1(7'h11);
    wr2(10'h022);
    for (int i = 0; i < 256; i++) wr3(15'h4000 + 15'(i));
    wr3(15'h0555);
    send({7'h11, 10'h022, 15'h0555}, 1'b0, 16'h0000, 257, 1'b1);
    wait_idle("full");
    check("stat_total_a", stat_total, 32'(exp_total));
    check("stat_compressed_a", stat_compressed, 32'(exp_comp));

    // Backpressure in DONE: outputs hold, dictionary writes ignored
    out_ready = 1'b0;
    send({7'h11, 10'h022, 15'h4005}, 1'b1, {3'd0, 5'd0, 8'd5}, 7, 1'b1);
    g = 0;
    while (!out_valid && g < 40) begin
      @(negedge clk);
      g++;
    end
    for (int i = 0; i < 5; i++) begin
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      check("hold_out_key", 32'(out_key), 32'h0005);
      check("hold_out_instr", out_instr, {7'h11, 10'h022, 15'h4005});
      dict1_write_enable = 1'b1;
      dict1_write_val    = 7'h33;
      @(negedge clk);
    end
    dict1_write_enable = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("release_out_valid", 32'(out_valid), 32'd0);
    check("release_in_ready", 32'(in_ready), 32'd1);
    wait_idle("hold");

    // Value written during DONE must not be present
    send({7'h33, 10'h022, 15'h4000}, 1'b0, 16'h0000, 2, 1'b1);
    wait_idle("ignored_write");

    // Write in the accepting cycle is searchable at index 1
    dict1_write_enable = 1'b1;
    dict1_write_val    = 7'h33;
    send({7'h33, 10'h022, 15'h4000}, 1'b1, {3'd1, 5'd0, 8'd0}, 3, 1'b1);
    dict1_write_enable = 1'b0;
    wait_idle("same_cycle_write");
    check("stat_total_b", stat_total, 32'(exp_total));
    check("stat_compressed_b", stat_compressed, 32'(exp_comp));

    // Reset during search cycle 10
    send({7'h11, 10'h022, 15'h4050}, 1'b1, {3'd0, 5'd0, 8'h50}, 82, 1'b0);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_total = 0;
    exp_comp  = 0;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_stat_total", stat_total, 32'd0);
    check("midrst_stat_compressed", stat_compressed, 32'd0);
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      if (out_valid) seen++;
      @(negedge clk);
    end
    check("midrst_no_output", 32'(seen), 32'd0);
    send({7'h11, 10'h022, 15'h4050}, 1'b1, {3'd0, 5'd0, 8'h50}, 82, 1'b1);
    wait_idle("requery");
    check("stat_total_c", stat_total, 32'(exp_total));
    check("stat_compressed_c", stat_compressed, 32'(exp_comp));
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/instr_compressor.md
Name: instr_compressor

Overview:
- Encoder counterpart to the decompressing fetch controller.
- Takes a 32-bit RV32 instruction and splits it into three fields (7/10/15 bits).
- Searches three loadable field dictionaries for each field and emits a 16-bit key word {key1,key2,key3} when all three fields hit; otherwise it flags the instruction uncompressible and passes it through.
- Used by the compressed-image build flow and the compression-ratio benches. Dictionaries are loaded through the same write-enable/value ports the decompressor uses.

Parameters:
- FIELD1_VAL_WIDTH, 7, width of field 1 = instr[31:25]
- FIELD2_VAL_WIDTH, 10, width of field 2 = instr[24:15]
- FIELD3_VAL_WIDTH, 15, width of field 3 = instr[14:0]
- FIELD1_KEY_WIDTH, 3, dict1 depth = 2**3 = 8
- FIELD2_KEY_WIDTH, 5, dict2 depth = 32
- FIELD3_KEY_WIDTH, 8, dict3 depth = 256

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- dict_clear  in  1  synchronous; zeroes all three write pointers/entry counts
- dict1_write_enable  in  1  write dict1[ptr1], ptr1++
- dict1_write_val  in  7  value written
- dict2_write_enable  in  1  write dict2[ptr2], ptr2++
- dict2_write_val  in  10  value written
- dict3_write_enable  in  1  write dict3[ptr3], ptr3++
- dict3_write_val  in  15  value written
- in_valid  in  1  instruction offered
- in_ready  out  1  high only in IDLE
- in_instr  in  32  instruction
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_compressed  out  1  1 = all three fields found
- out_key  out  16  {key1,key2,key3}; 0 when out_compressed=0
- out_instr  out  32  latched original instruction
- stat_total  out  32  results consumed
- stat_compressed  out  32  consumed results with out_compressed=1

Behaviour:
- Reset: state=IDLE; out_valid=0, out_compressed=0, out_key=0, out_instr=0, stat_total=0, stat_compressed=0.
- Reset does not touch dictionary contents, write pointers or counts. Only dict_clear clears pointers/counts; it has priority over same-cycle writes.
- Dictionary writes:
  - Accepted only in IDLE; ignored in SEARCH/DONE.
  - Pointer k saturates at depth k; writes when full are dropped.
  - count_k = number of valid entries. Entries at index >= count_k are never matched.
- FSM IDLE -> SEARCH:
  - Triggered by in_valid && in_ready at cycle T.
  - Latch in_instr, clear found flags, set idx=0.
- SEARCH, one index per cycle:
  - For each field k not yet resolved, compare dict_k[idx] to field k when idx < count_k.
  - Match: found_k=1, key_k=idx (lowest index wins on duplicates).
  - Field k becomes resolved when found, or when count_k==0, or when idx==count_k-1 was compared without a match.
- SEARCH -> DONE:
  - Occurs in the cycle in which all three fields are resolved; idx increments otherwise.
  - out_valid rises at end of that cycle.
  - Minimum latency: accept at T, out_valid visible at T+2.
  - Maximum latency: 256 search cycles (T+257).
- DONE:
  - out_valid=1; all outputs stable until out_ready.
  - out_compressed = found1&found2&found3.
  - out_key = {key1,key2,key3} if compressed, else 16'h0.
- DONE -> IDLE:
  - Occurs on out_ready; out_valid drops next cycle.
  - stat_total += 1; stat_compressed += out_compressed. Both counters wrap at 2**32.
  - in_ready is high one cycle after out_ready; no bypass.
- A write in the IDLE cycle that accepts an instruction lands before the first compare, so that entry is searchable.
- Reset mid-SEARCH/DONE: return to IDLE, result discarded, out_valid=0 next cycle.

Test Plan:
- Load dict1[0]=7'h00, dict2[3]=10'h0A5, dict3[17]=15'h0213 (other entries distinct), instr {7'h00,10'h0A5,15'h0213} -> out_compressed=1, out_key={3'd0,5'd3,8'd17}, out_valid at T+19.
- All counts 0 (dict_clear), instr 32'h00000013 -> out_valid at T+2, out_compressed=0, out_key=0, out_instr=32'h00000013.
- Field3 absent in full 256-entry dict3 -> out_valid at T+257, compressed=0; stat_total=1, stat_compressed=0 after out_ready.
- Duplicate value at dict2[4] and dict2[9] -> key2=4.
- Hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0, dict writes ignored (ptr unchanged); then out_ready=1 -> IDLE next cycle.
- Assert reset at search cycle 10 -> out_valid stays 0, in_ready=1 next cycle, re-query of the same instr gives an identical result (dictionaries retained).
